// File: rtl/fifo_stream_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader_if
//   Bundles the FIFO read port and the outgoing valid/ready stream used by
//   fifo_stream_reader.
//
//   FIFO side : fifo_empty, fifo_data (first-word-fall-through), fifo_r_ready
//   Stream    : m_valid, m_ready, m_data, m_last
//
//   master : the reader (pops the FIFO, drives the stream)
//   slave  : the environment (FIFO + downstream consumer)
// ---------------------------------------------------------------------------
interface fifo_stream_reader_if #(
  parameter int WIDTH = 32
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_r_ready;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_r_ready, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_r_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//   Drains a first-word-fall-through FIFO into a valid/ready stream through a
//   2-entry skid buffer, frames the stream into BURST_LEN-beat bursts with a
//   last flag, and counts accepted beats and bursts.
//
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset
//   i_enable    : level-sensitive run request
//   bus         : FIFO read port + output stream (master modport)
//   o_beat_cnt  : accepted beats, wraps
//   o_burst_cnt : accepted beats carrying last, wraps
//   o_idle      : state machine idle and skid buffer empty
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_enable,
  fifo_stream_reader_if.master      bus,
  output logic [CNT_WIDTH-1:0]      o_beat_cnt,
  output logic [CNT_WIDTH-1:0]      o_burst_cnt,
  output logic                      o_idle
);

  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [1:0]           r_occ;
  logic [WIDTH-1:0]     r_data [2];
  logic                 r_last [2];
  logic [IDX_W-1:0]     r_pop_idx;
  logic [IDX_W-1:0]     w_pop_idx_next;
  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic [CNT_WIDTH-1:0] r_burst_cnt;

  logic w_active;
  logic w_pop;
  logic w_accept;
  logic w_pop_last;
  logic w_wr_slot;

  assign w_active   = (r_state == ST_RUN) || (r_state == ST_FINISH);
  // Pop depends only on registered state and the FIFO flag, never on m_ready
  // or enable, so there is no combinational path from the stream back to the FIFO.
  assign w_pop      = w_active && !bus.fifo_empty && (r_occ != 2'd2);
  assign w_accept   = (r_occ != 2'd0) && bus.m_ready;
  assign w_pop_last = (r_pop_idx == LAST_IDX);

  // Entry 0 is always the head. A new word lands at slot (occ - accept):
  // slot 1 only when one word is already held and it is not leaving.
  assign w_wr_slot  = (r_occ == 2'd1) && !w_accept;

  assign w_pop_idx_next = !w_pop     ? r_pop_idx :
                          w_pop_last ? '0        :
                                       r_pop_idx + 1'b1;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        // A burst that is partly popped must be completed before stopping.
        if (!i_enable) w_state_next = (w_pop_idx_next == '0) ? ST_IDLE : ST_FINISH;
      end
      ST_FINISH: begin
        if (i_enable)                 w_state_next = ST_RUN;
        else if (w_pop && w_pop_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_occ       <= 2'd0;
      r_pop_idx   <= '0;
      r_beat_cnt  <= '0;
      r_burst_cnt <= '0;
      r_data[0]   <= '0;
      r_data[1]   <= '0;
      r_last[0]   <= 1'b0;
      r_last[1]   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pop_idx <= w_pop_idx_next;
      r_occ     <= r_occ + {1'b0, w_pop} - {1'b0, w_accept};

      // Shift on accept first; a pop into slot 0 in the same cycle overrides.
      if (w_accept) begin
        r_data[0] <= r_data[1];
        r_last[0] <= r_last[1];
      end
      if (w_pop) begin
        r_data[w_wr_slot] <= bus.fifo_data;
        r_last[w_wr_slot] <= w_pop_last;
      end

      if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
        if (r_last[0]) r_burst_cnt <= r_burst_cnt + 1'b1;
      end
    end
  end

  assign bus.fifo_r_ready = w_pop;
  assign bus.m_valid      = (r_occ != 2'd0);
  assign bus.m_data       = r_data[0];
  assign bus.m_last       = r_last[0];
  assign o_beat_cnt       = r_beat_cnt;
  assign o_burst_cnt      = r_burst_cnt;
  assign o_idle           = (r_state == ST_IDLE) && (r_occ == 2'd0);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//   A queue stands in for the FIFO. Every pop pushes {last, data} onto the
//   expected queue, with last taken from the running pop count since reset
//   (every BURST_LEN-th word). A separate monitor pops and compares on each
//   accepted beat and tracks beat/burst totals.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;
  localparam int WIDTH = 32;
  localparam int BL    = 4;
  localparam int CW    = 16;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          enable = 1'b0;
  logic          gap    = 1'b0;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] burst_cnt;
  logic          idle;

  fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();

  fifo_stream_reader #(.WIDTH(WIDTH), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (enable),
    .bus        (bus),
    .o_beat_cnt (beat_cnt),
    .o_burst_cnt(burst_cnt),
    .o_idle     (idle)
  );

  always #5 clk = ~clk;

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH:0]   exp_q[$];
  int               pop_cnt = 0;
  logic [CW-1:0]    beats_m = '0;
  logic [CW-1:0]    bursts_m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(WIDTH'(base + i));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (!(idle === 1'b1 && exp_q.size() == 0) && k < budget) begin
      cyc(1);
      k++;
    end
    chk(name, idle, 1'b1);
  endtask

  task automatic wait_flush(input string name, input int budget);
    int k = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
      cyc(1);
      k++;
    end
    chk(name, fifo_q.size() + exp_q.size(), 0);
  endtask

  // FIFO model: presents the head word, removes it on a pop edge.
  initial begin : fifo_model
    bit will_pop;
    bit rst_s;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    forever begin
      @(negedge clk);
      bus.fifo_empty = gap || (fifo_q.size() == 0);
      bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
      #1;
      rst_s    = reset;
      will_pop = bus.fifo_r_ready;
      if (will_pop && !rst_s) chk("rready_while_empty", bus.fifo_empty, 1'b0);
      @(posedge clk);
      if (rst_s) begin
        pop_cnt = 0;
      end else if (will_pop && fifo_q.size() != 0) begin
        exp_q.push_back({((pop_cnt % BL) == (BL - 1)), fifo_q.pop_front()});
        pop_cnt++;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin : monitor
    logic [WIDTH:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        exp_q.delete();
        beats_m  = '0;
        bursts_m = '0;
      end else begin
        chk("m_valid_vs_occ", bus.m_valid, exp_q.size() != 0);
        if (exp_q.size() == 2) chk("rready_when_full", bus.fifo_r_ready, 1'b0);
        chk("beat_cnt", beat_cnt, beats_m);
        chk("burst_cnt", burst_cnt, bursts_m);
        if (bus.m_valid && bus.m_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("m_data", bus.m_data, e[WIDTH-1:0]);
          chk("m_last", bus.m_last, e[WIDTH]);
          beats_m++;
          if (e[WIDTH]) bursts_m++;
          $display("[TB] beat %0d data=%0h last=%0b", beats_m, bus.m_data, bus.m_last);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int k;
    int nvalid;
    bus.m_ready = 1'b1;
    enable      = 1'b1;
    push_words(0, 10);

    // Reset held two cycles with FIFO non-empty and enable high.
    cyc(1);
    chk("rst_rready", bus.fifo_r_ready, 1'b0);
    chk("rst_valid", bus.m_valid, 1'b0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_burst", burst_cnt, 0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_data", bus.m_data, 0);
    cyc(1);
    chk("rst2_rready", bus.fifo_r_ready, 1'b0);
    chk("rst2_valid", bus.m_valid, 1'b0);
    reset = 1'b0;

    // Streaming 0..9 with m_ready high.
    cyc(1);
    chk("run_rready", bus.fifo_r_ready, 1'b1);
    chk("pre_pop_valid", bus.m_valid, 1'b0);
    cyc(1);
    chk("first_valid", bus.m_valid, 1'b1);
    chk("first_data", bus.m_data, 0);
    nvalid = 0;
    k = 0;
    while (bus.m_valid && k < 30) begin
      nvalid++;
      cyc(1);
      k++;
    end
    chk("stream_consecutive", nvalid, 10);
    chk("stream_beats", beat_cnt, 10);
    chk("stream_bursts", burst_cnt, 2);

    // Backpressure.
    bus.m_ready = 1'b0;
    push_words(100, 10);
    cyc(5);
    chk("bp_pops", fifo_q.size(), 8);
    chk("bp_rready", bus.fifo_r_ready, 1'b0);
    chk("bp_head", bus.m_data, 100);
    chk("bp_valid", bus.m_valid, 1'b1);
    bus.m_ready = 1'b1;
    wait_flush("bp_flush", 60);

    // Enable drop mid-burst.
    push_words(200, 5);
    k = 0;
    while (pop_cnt < 22 && k < 20) begin
      cyc(1);
      k++;
    end
    enable = 1'b0;
    wait_idle("drop_idle", 30);
    chk("drop_left", fifo_q.size(), 1);
    chk("drop_aligned", pop_cnt % BL, 0);
    cyc(5);
    chk("idle_no_pop", fifo_q.size(), 1);

    // Underflow gap after two beats of a burst.
    enable = 1'b1;
    push_words(205, 1);
    k = 0;
    while (pop_cnt < 26 && k < 20) begin
      cyc(1);
      k++;
    end
    gap = 1'b1;
    push_words(206, 2);
    cyc(3);
    chk("gap_valid", bus.m_valid, 1'b0);
    gap = 1'b0;
    wait_flush("gap_flush", 30);
    chk("gap_beats", beat_cnt, 28);
    chk("gap_bursts", burst_cnt, 7);

    // Reset mid-operation with a full buffer.
    bus.m_ready = 1'b0;
    push_words(300, 10);
    k = 0;
    while (exp_q.size() < 2 && k < 20) begin
      cyc(1);
      k++;
    end
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mid_rst_valid", bus.m_valid, 1'b0);
    chk("mid_rst_beat", beat_cnt, 0);
    chk("mid_rst_burst", burst_cnt, 0);
    chk("mid_rst_idle", idle, 1'b1);
    chk("mid_rst_rready", bus.fifo_r_ready, 1'b0);
    bus.m_ready = 1'b1;
    wait_flush("mid_rst_flush", 60);
    chk("mid_rst_beats", beat_cnt, 8);
    chk("mid_rst_bursts", burst_cnt, 2);

    // Randomized traffic: stalls, FIFO gaps, enable toggling.
    for (int c = 0; c < 400; c++) begin
      bus.m_ready = ($urandom_range(0, 99) < 70);
      gap         = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) < 6) enable = ~enable;
      if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) fifo_q.push_back($urandom);
      cyc(1);
    end
    gap         = 1'b0;
    bus.m_ready = 1'b1;
    enable      = 1'b0;
    push_words(500, BL);
    wait_idle("rand_idle", 200);
    chk("rand_aligned", pop_cnt % BL, 0);
    chk("rand_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
